// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings and state constants for the microprogrammed control unit
package control_pkg;

    localparam int STATE_W = 7;

    // Next-state source select, from the microstore word
    localparam logic [2:0] NS_DISPATCH = 3'b000;
    localparam logic [2:0] NS_FETCH    = 3'b001;
    localparam logic [2:0] NS_JUMP     = 3'b010;
    localparam logic [2:0] NS_INC      = 3'b011;
    localparam logic [2:0] NS_BRANCH   = 3'b100;
    localparam logic [2:0] NS_WAIT     = 3'b101;
    localparam logic [2:0] NS_HOLD     = 3'b110;
    localparam logic [2:0] NS_ZERO     = 3'b111;

    localparam logic [1:0] COND_MOC  = 2'b00;
    localparam logic [1:0] COND_ZERO = 2'b01;
    localparam logic [1:0] COND_NEG  = 2'b10;
    localparam logic [1:0] COND_ONE  = 2'b11;

    localparam logic [STATE_W-1:0] ST_FETCH = 7'd0;

    localparam logic [STATE_W-1:0] ST_ADD   = 7'd6;
    localparam logic [STATE_W-1:0] ST_ADDU  = 7'd7;
    localparam logic [STATE_W-1:0] ST_SUB   = 7'd8;
    localparam logic [STATE_W-1:0] ST_SUBU  = 7'd9;
    localparam logic [STATE_W-1:0] ST_AND   = 7'd10;
    localparam logic [STATE_W-1:0] ST_OR    = 7'd11;
    localparam logic [STATE_W-1:0] ST_SLT   = 7'd12;
    localparam logic [STATE_W-1:0] ST_SLTU  = 7'd13;
    localparam logic [STATE_W-1:0] ST_ADDI  = 7'd14;
    localparam logic [STATE_W-1:0] ST_ADDIU = 7'd15;
    localparam logic [STATE_W-1:0] ST_ANDI  = 7'd16;
    localparam logic [STATE_W-1:0] ST_ORI   = 7'd17;
    localparam logic [STATE_W-1:0] ST_LUI   = 7'd18;
    localparam logic [STATE_W-1:0] ST_LW    = 7'd19;
    localparam logic [STATE_W-1:0] ST_SW    = 7'd20;
    localparam logic [STATE_W-1:0] ST_BEQ   = 7'd21;
    localparam logic [STATE_W-1:0] ST_BNE   = 7'd22;
    localparam logic [STATE_W-1:0] ST_J     = 7'd23;
    localparam logic [STATE_W-1:0] ST_JAL   = 7'd24;

    localparam logic [STATE_W-1:0] EXC_STATE_DFLT = 7'd61;
    localparam logic [STATE_W-1:0] ILL_STATE_DFLT = 7'd62;

endpackage

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - combinational opcode/funct to dispatch-state map
module instruction_encoder
    import control_pkg::*;
#(
    parameter logic [6:0] ILL_STATE = ILL_STATE_DFLT
) (
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [6:0] dispatch_state
);

    always_comb begin
        dispatch_state = ILL_STATE;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20:   dispatch_state = ST_ADD;
                6'h21:   dispatch_state = ST_ADDU;
                6'h22:   dispatch_state = ST_SUB;
                6'h23:   dispatch_state = ST_SUBU;
                6'h24:   dispatch_state = ST_AND;
                6'h25:   dispatch_state = ST_OR;
                6'h2A:   dispatch_state = ST_SLT;
                6'h2B:   dispatch_state = ST_SLTU;
                default: dispatch_state = ILL_STATE;
            endcase
        end else begin
            case (opcode)
                6'h08:   dispatch_state = ST_ADDI;
                6'h09:   dispatch_state = ST_ADDIU;
                6'h0C:   dispatch_state = ST_ANDI;
                6'h0D:   dispatch_state = ST_ORI;
                6'h0F:   dispatch_state = ST_LUI;
                6'h23:   dispatch_state = ST_LW;
                6'h2B:   dispatch_state = ST_SW;
                6'h04:   dispatch_state = ST_BEQ;
                6'h05:   dispatch_state = ST_BNE;
                6'h02:   dispatch_state = ST_J;
                6'h03:   dispatch_state = ST_JAL;
                default: dispatch_state = ILL_STATE;
            endcase
        end
    end

endmodule

// File: rtl/microsequencer.sv
// rtl/microsequencer.sv - control-state register, next-state mux and memory-wait watchdog
module microsequencer
    import control_pkg::*;
#(
    parameter int         MOC_TIMEOUT = 16,
    parameter logic [6:0] EXC_STATE   = EXC_STATE_DFLT,
    parameter logic [6:0] ILL_STATE   = ILL_STATE_DFLT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] nsSel,
    input  logic [1:0] condSel,
    input  logic       inv,
    input  logic [6:0] crAddr,
    input  logic       moc,
    input  logic       zero,
    input  logic       neg,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [6:0] currentState,
    output logic       busError
);

    localparam int CNT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);

    logic [6:0]       state_q, state_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    logic [6:0] dispatch_state;
    logic [6:0] state_inc;
    logic [6:0] mux_state;
    logic       cond_raw;
    logic       cond;
    logic       stall;
    logic       expire;

    instruction_encoder #(
        .ILL_STATE(ILL_STATE)
    ) u_encoder (
        .opcode        (opcode),
        .funct         (funct),
        .dispatch_state(dispatch_state)
    );

    assign state_inc = state_q + 7'd1;

    always_comb begin
        cond_raw = 1'b1;
        case (condSel)
            COND_MOC:  cond_raw = moc;
            COND_ZERO: cond_raw = zero;
            COND_NEG:  cond_raw = neg;
            default:   cond_raw = 1'b1;
        endcase
        cond = cond_raw ^ inv;
    end

    always_comb begin
        mux_state = state_q;
        case (nsSel)
            NS_DISPATCH: mux_state = dispatch_state;
            NS_FETCH:    mux_state = ST_FETCH;
            NS_JUMP:     mux_state = crAddr;
            NS_INC:      mux_state = state_inc;
            NS_BRANCH:   mux_state = cond ? crAddr : state_inc;
            NS_WAIT:     mux_state = cond ? state_inc : state_q;
            NS_HOLD:     mux_state = state_q;
            default:     mux_state = ST_FETCH;
        endcase
    end

    // A satisfied condition in the expiry cycle is not a stall, so it advances normally.
    always_comb begin
        stall     = (nsSel == NS_WAIT) && !cond;
        expire    = stall && (wd_cnt_q == CNT_LAST);
        wd_cnt_d  = (stall && !expire) ? (wd_cnt_q + CNT_W'(1)) : '0;
        state_d   = expire ? EXC_STATE : mux_state;
        bus_err_d = expire;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            bus_err_q <= 1'b0;
            wd_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
            wd_cnt_q  <= wd_cnt_d;
        end
    end

    assign currentState = state_q;
    assign busError     = bus_err_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb/tb_microsequencer.sv - directed self-checking bench for microsequencer
module tb_microsequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] nsSel = 3'b110;
    logic [1:0] condSel = 2'b00;
    logic       inv = 1'b0;
    logic [6:0] crAddr = 7'd0;
    logic       moc = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic [6:0] currentState;
    logic       busError;

    int n_checks = 0;
    int n_fail = 0;

    microsequencer dut (
        .clk         (clk),
        .reset       (reset),
        .nsSel       (nsSel),
        .condSel     (condSel),
        .inv         (inv),
        .crAddr      (crAddr),
        .moc         (moc),
        .zero        (zero),
        .neg         (neg),
        .opcode      (opcode),
        .funct       (funct),
        .currentState(currentState),
        .busError    (busError)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_state(input logic [6:0] s);
        nsSel  = 3'b010;
        crAddr = s;
        step();
        check("load_state", int'(currentState), int'(s));
    endtask

    initial begin
        #2;
        check("reset_state", int'(currentState), 0);
        check("reset_buserr", int'(busError), 0);
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset mid-cycle from state 20
        load_state(7'd20);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", int'(currentState), 0);
        check("async_rst_buserr", int'(busError), 0);
        @(negedge clk);
        reset = 1'b0;

        nsSel = 3'b000; opcode = 6'h23; funct = 6'h00;
        step(); check("dispatch_lw", int'(currentState), 19);
        opcode = 6'h00; funct = 6'h2A;
        step(); check("dispatch_slt", int'(currentState), 12);
        opcode = 6'h3F;
        step(); check("dispatch_ill_op", int'(currentState), 62);
        opcode = 6'h00; funct = 6'h3F;
        step(); check("dispatch_ill_funct", int'(currentState), 62);
        opcode = 6'h03;
        step(); check("dispatch_jal", int'(currentState), 24);

        nsSel = 3'b001;
        step(); check("ns_fetch", int'(currentState), 0);

        // Conditional branch on zero
        load_state(7'd30);
        nsSel = 3'b100; condSel = 2'b01; crAddr = 7'd40; zero = 1'b1; inv = 1'b0;
        step(); check("branch_taken", int'(currentState), 40);
        load_state(7'd30);
        nsSel = 3'b100; condSel = 2'b01; crAddr = 7'd40; zero = 1'b1; inv = 1'b1;
        step(); check("branch_inv_not_taken", int'(currentState), 31);
        nsSel = 3'b100; condSel = 2'b11; crAddr = 7'd40; inv = 1'b1;
        step(); check("branch_never", int'(currentState), 32);
        inv = 1'b0; zero = 1'b0;

        load_state(7'd127);
        nsSel = 3'b011;
        step(); check("inc_wrap", int'(currentState), 0);

        load_state(7'd45);
        nsSel = 3'b110;
        step(); check("hold", int'(currentState), 45);
        nsSel = 3'b111;
        step(); check("ns_zero", int'(currentState), 0);

        // Memory wait: 5 stalls then moc
        load_state(7'd50);
        nsSel = 3'b101; condSel = 2'b00; inv = 1'b0; moc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("wait_stall_state", int'(currentState), 50);
            check("wait_stall_buserr", int'(busError), 0);
        end
        moc = 1'b1;
        step();
        check("wait_advance", int'(currentState), 51);
        check("wait_advance_buserr", int'(busError), 0);

        // Timeout after exactly 16 stalled cycles
        load_state(7'd50);
        nsSel = 3'b101; moc = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_stall_state", int'(currentState), 50);
            check("to_stall_buserr", int'(busError), 0);
        end
        step();
        check("timeout_state", int'(currentState), 61);
        check("timeout_buserr", int'(busError), 1);
        nsSel = 3'b110;
        step();
        check("post_timeout_state", int'(currentState), 61);
        check("post_timeout_buserr", int'(busError), 0);

        // moc arriving on the 16th cycle wins over expiry
        load_state(7'd50);
        nsSel = 3'b101; moc = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("late_moc_pre", int'(currentState), 50);
        moc = 1'b1;
        step();
        check("late_moc_state", int'(currentState), 51);
        check("late_moc_buserr", int'(busError), 0);

        // Counter cleared by the advance: a fresh wait needs a full 16 stalls again
        load_state(7'd50);
        nsSel = 3'b101; moc = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("fresh_wait_15", int'(currentState), 50);
        check("fresh_wait_15_buserr", int'(busError), 0);
        step();
        check("fresh_wait_16", int'(currentState), 61);

        // Reset mid-wait gives no busError
        load_state(7'd50);
        nsSel = 3'b101; moc = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 reset = 1'b1;
        #1;
        check("rst_mid_wait_state", int'(currentState), 0);
        check("rst_mid_wait_buserr", int'(busError), 0);
        @(negedge clk);
        nsSel = 3'b110;
        reset = 1'b0;
        step();
        check("after_rst_buserr", int'(busError), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microsequencer.md
# microsequencer

Next-state generator and state register for the microprogrammed MIPS control unit. It sits directly upstream of the microstore: it holds the 7-bit current control state and drives it to the microstore. Each cycle it selects the next state from the microstore's sequencing fields, the datapath status flags and the decoded instruction. A memory-wait watchdog diverts stalled microprograms to an exception state.

## Interface
- `MOC_TIMEOUT`, 16: maximum consecutive wait cycles on MOC before a bus error.
- `EXC_STATE`, 7'd61: state entered on a bus-error timeout.
- `ILL_STATE`, 7'd62: dispatch target for unrecognised instructions.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `nsSel`  in  3  next-state source select; from the microstore word.
- `condSel`  in  2  condition select: 00 MOC, 01 zero, 10 negative, 11 constant 1.
- `inv`  in  1  inverts the selected condition.
- `crAddr`  in  7  jump target field; from the microstore word.
- `moc`  in  1  memory operation complete.
- `zero`, `neg`  in  1 each  ALU status flags (already latched by the datapath).
- `opcode`, `funct`  in  6 each  fields of the instruction register.
- `currentState`  out  7  registered control state; feeds the microstore.
- `busError`  out  1  registered one-cycle pulse on watchdog expiry.

## Operation
- Condition: c = sel(condSel) XOR inv. Constant 1 with inv=1 is "never".
- Next-state mux by `nsSel`:
  - 000: encoder output (dispatch)
  - 001: 7'd0 (fetch)
  - 010: crAddr
  - 011: currentState+1
  - 100: c ? crAddr : currentState+1
  - 101 (wait): c ? currentState+1 : currentState
  - 110: hold
  - 111: 7'd0
- Incrementer is 7-bit and wraps 127→0.
- Encoder, used when opcode=0x00 (R-type), keyed on funct:
  - 0x20→6, 0x21→7, 0x22→8, 0x23→9, 0x24→10, 0x25→11, 0x2A→12, 0x2B→13
  - any other funct → ILL_STATE.
- Encoder, for all other opcodes:
  - 0x08→14, 0x09→15, 0x0C→16, 0x0D→17, 0x0F→18
  - 0x23→19, 0x2B→20, 0x04→21, 0x05→22, 0x02→23, 0x03→24
  - any other opcode → ILL_STATE.
- Watchdog counter:
  - Counts cycles where nsSel=101 and c=0, i.e. stalled in a wait.
  - Cleared on any cycle that is not such a stall.
- Watchdog expiry:
  - Applies when the counter equals MOC_TIMEOUT-1 and the current cycle is still a stall.
  - Next state is forced to EXC_STATE, `busError` is 1 in the following cycle, and the counter clears.
- No other state overrides the mux.

## Timing
- Reset, asynchronous: `currentState`=0, `busError`=0, watchdog counter=0.
- After reset deassertion, the first edge loads the next state computed from state 0's microword.
- The microstore is combinational on `currentState`: control fields and next state settle in the same cycle. One microinstruction per cycle; latency is 1 clock from the inputs to `currentState`.
- Wait with `moc` rising in cycle k: `currentState` advances at edge k+1, and the counter clears at the same edge.
- `moc`=1 in the same cycle the counter expires: the condition wins; normal advance, no `busError`.
- A wait of exactly MOC_TIMEOUT stalled cycles triggers the timeout. MOC_TIMEOUT-1 stalled cycles followed by `moc` does not.
- `busError` is high for exactly one cycle per timeout, concurrent with `currentState`=EXC_STATE.
- Reset mid-wait or mid-dispatch: immediate return to state 0, with no `busError` pulse.
- The counter saturates logically because it clears at expiry; its width is $clog2(MOC_TIMEOUT).

## Structure
- Shared package `control_pkg` holds:
  - nsSel encodings and condSel encodings as named constants
  - state width (7)
  - encoder state constants (6–24)
  - the default EXC_STATE/ILL_STATE values
- Sub-module `instruction_encoder`: purely combinational map from opcode/funct to dispatch state.
- The sequencer top holds the mux, condition logic, watchdog and state register.

## Test plan
- Reset asserted asynchronously mid-cycle while `currentState`=20 → `currentState`=0 immediately, `busError`=0, no clock needed.
- nsSel=000 with opcode=0x23 → next `currentState`=19. With opcode=0x00, funct=0x2A → 12. With opcode=0x3F → 62.
- Conditional branch: nsSel=100, condSel=01, crAddr=40, in state 30.
  - zero=1, inv=0 → 40.
  - zero=1, inv=1 → 31.
  - state 127 with nsSel=011 → 0 (wrap).
- Memory wait: nsSel=101, condSel=00, in state 50, `moc`=0 for 5 cycles then 1 → `currentState` stays 50 for 5 edges, then 51; `busError` never set.
- Timeout: `moc` held 0 in the wait state for 16 cycles → `currentState`=61 on the 16th edge, `busError`=1 for exactly that cycle. `moc`=1 arriving on the 16th cycle → 51 instead, no `busError`.
